// File: rtl/dram_sched_ctrl.sv
// Multi-channel DRAM command scheduler: per-channel request FIFOs, round-robin grant,
// PRE/ACT/RW sequencing with open-row tracking. Define OPEN_PAGE_EN for the open-page policy.

module dram_sched_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         not_empty,
  output logic         ready
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   cnt, cnt_d;
  logic          wr_en;

  assign wr_en     = push && ready;
  assign cnt_d     = cnt + (PW+1)'(wr_en) - (PW+1)'(pop);
  assign dout      = mem[rd_ptr];
  assign not_empty = (cnt != '0);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      ready  <= 1'b1;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      cnt   <= cnt_d;
      ready <= (cnt_d != (PW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end
endmodule

module dram_sched_ctrl #(
  parameter int  NUM_OF_REQ   = 8,
  parameter int  ADDR_WIDTH   = 22,
  parameter int  DATA_WIDTH   = 1,
  parameter int  NUM_OF_BANKS = 8,
  parameter int  NUM_OF_ROWS  = 128,
  parameter int  NUM_OF_COLS  = 8,
  parameter int  QUEUE_DEPTH  = 4,
  parameter int  T_RP         = 2,
  parameter int  T_RCD        = 2,
  parameter int  T_CL         = 3,
  localparam int BANK_W = $clog2(NUM_OF_BANKS),
  localparam int ROW_W  = $clog2(NUM_OF_ROWS),
  localparam int COL_W  = $clog2(NUM_OF_COLS),
  localparam int ID_W   = (NUM_OF_REQ > 1) ? $clog2(NUM_OF_REQ) : 1
) (
  input  logic                             clk,
  input  logic                             rst_b,
  input  logic [NUM_OF_REQ-1:0]            req_valid,
  output logic [NUM_OF_REQ-1:0]            req_ready,
  input  logic [NUM_OF_REQ-1:0]            req_rw,
  input  logic [NUM_OF_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_OF_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]                       cmd,
  output logic [BANK_W-1:0]                bank_sel,
  output logic [ROW_W-1:0]                 row_addr,
  output logic [COL_W-1:0]                 col_addr,
  output logic                             dram_we,
  output logic [DATA_WIDTH-1:0]            dram_data_out,
  input  logic [DATA_WIDTH-1:0]            dram_data_in,
  output logic                             rsp_valid,
  output logic [ID_W-1:0]                  rsp_id,
  output logic                             rsp_rw,
  output logic [DATA_WIDTH-1:0]            rsp_data
);
  localparam int ENT_W = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int T_MAX = (T_RP > T_RCD) ? ((T_RP > T_CL) ? T_RP : T_CL)
                                        : ((T_RCD > T_CL) ? T_RCD : T_CL);
  localparam int CNT_W = $clog2(T_MAX + 1);
  localparam logic [CNT_W-1:0] RP_LD  = CNT_W'((T_RP  > 1) ? T_RP  - 2 : 0);
  localparam logic [CNT_W-1:0] RCD_LD = CNT_W'((T_RCD > 1) ? T_RCD - 2 : 0);
  localparam logic [CNT_W-1:0] CL_LD  = CNT_W'(T_CL - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ACT, S_RW, S_WAIT, S_RDWAIT, S_CPRE} state_t;
`ifdef OPEN_PAGE_EN
  localparam state_t S_DONE = S_IDLE;
`else
  localparam state_t S_DONE = S_CPRE;
`endif

  state_t state, state_d, wait_tgt, tgt_d;
  logic [CNT_W-1:0] tmr, tmr_d;

  logic [NUM_OF_REQ-1:0]            fifo_ne, fifo_pop;
  logic [NUM_OF_REQ-1:0][ENT_W-1:0] fifo_head;
  logic [ID_W-1:0]                  rr_ptr, win;
  logic                             grant;

  logic [ENT_W-1:0]      hd;
  logic [ADDR_WIDTH-1:0] hd_addr;
  logic [BANK_W-1:0]     hd_bank;
  logic [ROW_W-1:0]      hd_row;

  logic [ID_W-1:0]       w_id;
  logic                  w_rw;
  logic [BANK_W-1:0]     w_bank;
  logic [ROW_W-1:0]      w_row;
  logic [COL_W-1:0]      w_col;
  logic [DATA_WIDTH-1:0] w_wdata;

  logic [NUM_OF_BANKS-1:0]            open_vld;
  logic [NUM_OF_BANKS-1:0][ROW_W-1:0] open_row;
  logic [BANK_W-1:0] bank_q;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  logic              cmd_cyc;

  for (genvar i = 0; i < NUM_OF_REQ; i++) begin : g_ch
    dram_sched_fifo #(.W(ENT_W), .DEPTH(QUEUE_DEPTH)) u_fifo (
      .clk       (clk),
      .rst_b     (rst_b),
      .push      (req_valid[i]),
      .pop       (fifo_pop[i]),
      .din       ({req_rw[i], req_addr[i*ADDR_WIDTH +: ADDR_WIDTH],
                   req_wdata[i*DATA_WIDTH +: DATA_WIDTH]}),
      .dout      (fifo_head[i]),
      .not_empty (fifo_ne[i]),
      .ready     (req_ready[i])
    );
  end

  // Round-robin: first non-empty channel at or after the pointer, only while idle.
  always_comb begin
    int idx;
    idx   = 0;
    grant = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_OF_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_OF_REQ) idx = idx - NUM_OF_REQ;
      if (!grant && fifo_ne[idx]) begin
        grant = 1'b1;
        win   = ID_W'(idx);
      end
    end
    if (state != S_IDLE) grant = 1'b0;
  end

  always_comb begin
    fifo_pop = '0;
    for (int i = 0; i < NUM_OF_REQ; i++) fifo_pop[i] = grant && (win == ID_W'(i));
  end

  assign hd      = fifo_head[win];
  assign hd_addr = hd[DATA_WIDTH +: ADDR_WIDTH];
  assign hd_bank = hd_addr[COL_W +: BANK_W];
  assign hd_row  = hd_addr[COL_W+BANK_W +: ROW_W];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= S_IDLE;
      wait_tgt <= S_IDLE;
      tmr      <= '0;
    end else begin
      state    <= state_d;
      wait_tgt <= tgt_d;
      tmr      <= tmr_d;
    end
  end

  always_comb begin
    state_d = state;
    tgt_d   = wait_tgt;
    tmr_d   = tmr;
    case (state)
      S_IDLE: if (grant) begin
        if (!open_vld[hd_bank])               state_d = S_ACT;
        else if (open_row[hd_bank] == hd_row) state_d = S_RW;
        else                                  state_d = S_PRE;
      end
      S_PRE: begin
        state_d = (T_RP > 1) ? S_WAIT : S_ACT;
        tgt_d   = S_ACT;
        tmr_d   = RP_LD;
      end
      S_ACT: begin
        state_d = (T_RCD > 1) ? S_WAIT : S_RW;
        tgt_d   = S_RW;
        tmr_d   = RCD_LD;
      end
      S_RW: begin
        state_d = w_rw ? S_DONE : S_RDWAIT;
        tmr_d   = CL_LD;
      end
      S_WAIT: begin
        if (tmr == '0) state_d = wait_tgt;
        else           tmr_d   = tmr - CNT_W'(1);
      end
      S_RDWAIT: begin
        if (tmr == '0) state_d = S_DONE;
        else           tmr_d   = tmr - CNT_W'(1);
      end
      S_CPRE: begin
        // Closing precharge overlaps the response; hold off new grants for tRP.
        state_d = (T_RP > 1) ? S_WAIT : S_IDLE;
        tgt_d   = S_IDLE;
        tmr_d   = RP_LD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd     = 2'b00;
    dram_we = 1'b0;
    case (state)
      S_PRE, S_CPRE: cmd = 2'b11;
      S_ACT:         cmd = 2'b01;
      S_RW: begin
        cmd     = 2'b10;
        dram_we = w_rw;
      end
      default: cmd = 2'b00;
    endcase
  end

  assign cmd_cyc       = (cmd != 2'b00);
  assign bank_sel      = cmd_cyc ? w_bank : bank_q;
  assign row_addr      = cmd_cyc ? w_row  : row_q;
  assign col_addr      = cmd_cyc ? w_col  : col_q;
  assign dram_data_out = dram_we ? w_wdata : '0;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rr_ptr    <= '0;
      w_id      <= '0;
      w_rw      <= 1'b0;
      w_bank    <= '0;
      w_row     <= '0;
      w_col     <= '0;
      w_wdata   <= '0;
      open_vld  <= '0;
      open_row  <= '0;
      bank_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_rw    <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (grant) begin
        w_id    <= win;
        w_rw    <= hd[ENT_W-1];
        w_bank  <= hd_bank;
        w_row   <= hd_row;
        w_col   <= hd_addr[COL_W-1:0];
        w_wdata <= hd[DATA_WIDTH-1:0];
        rr_ptr  <= (win == ID_W'(NUM_OF_REQ-1)) ? '0 : win + ID_W'(1);
      end
      if (cmd_cyc) begin
        bank_q <= w_bank;
        row_q  <= w_row;
        col_q  <= w_col;
      end
      if (state == S_ACT) begin
        open_vld[w_bank] <= 1'b1;
        open_row[w_bank] <= w_row;
      end
      if (state == S_PRE || state == S_CPRE) open_vld[w_bank] <= 1'b0;
      if (state == S_RW && w_rw) begin
        rsp_valid <= 1'b1;
        rsp_id    <= w_id;
        rsp_rw    <= 1'b1;
        rsp_data  <= '0;
      end
      if (state == S_RDWAIT && tmr == '0) begin
        rsp_valid <= 1'b1;
        rsp_id    <= w_id;
        rsp_rw    <= 1'b0;
        rsp_data  <= dram_data_in;
      end
    end
  end
endmodule

// File: tb/tb_dram_sched_ctrl.sv
// Randomized bench for dram_sched_ctrl: a transaction timeline model predicts every
// command, ready flag and response cycle by cycle from the scheduling rules.
module tb_dram_sched_ctrl;
  localparam int NREQ = 8, AW = 22, DW = 1, NB = 8, NR = 128, NC = 8, QD = 4;
  localparam int TRP = 2, TRCD = 2, TCL = 3;
  localparam int BW = 3, RWW = 7, CW = 3, IDW = 3;

  logic clk = 1'b0;
  logic rst_b;
  logic [NREQ-1:0]    req_valid, req_ready, req_rw;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [1:0]         cmd;
  logic [BW-1:0]      bank_sel;
  logic [RWW-1:0]     row_addr;
  logic [CW-1:0]      col_addr;
  logic               dram_we;
  logic [DW-1:0]      dram_data_out, dram_data_in;
  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic               rsp_rw;
  logic [DW-1:0]      rsp_data;

  dram_sched_ctrl #(
    .NUM_OF_REQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_OF_BANKS(NB),
    .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC), .QUEUE_DEPTH(QD),
    .T_RP(TRP), .T_RCD(TRCD), .T_CL(TCL)
  ) dut (
    .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata), .cmd(cmd),
    .bank_sel(bank_sel), .row_addr(row_addr), .col_addr(col_addr), .dram_we(dram_we),
    .dram_data_out(dram_data_out), .dram_data_in(dram_data_in), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_rw(rsp_rw), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  typedef struct { bit rw; int bank; int row; int col; int hi; logic [DW-1:0] wd; } mreq_t;
  typedef struct { bit [1:0] cmd; int bank; int row; int col; bit we; logic [DW-1:0] wd; } ev_t;
  typedef struct { int id; bit rw; int dcyc; } rsp_t;

  mreq_t         mq [NREQ][$];
  ev_t           ev [int];
  rsp_t          er [int];
  logic [DW-1:0] din_hist [int];
  int            orow [NB];
  int            ptr, free_c, last_rsp, plan_act, cyc, last_bank;
  int            n_chk, n_err;

  logic [NREQ-1:0] d_vld;
  mreq_t           d_req [NREQ];
  logic [NREQ-1:0] ones;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc %0d got %0h exp %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] mk_addr(input mreq_t r);
    logic [AW-1:0] a;
    a = (AW'(r.hi) << (CW+BW+RWW)) | (AW'(r.row) << (CW+BW)) | (AW'(r.bank) << CW) | AW'(r.col);
    return a;
  endfunction

  function automatic mreq_t mk_req(input bit rw, input int bank, input int row, input int col);
    mreq_t r;
    r.rw = rw; r.bank = bank; r.row = row; r.col = col; r.hi = 0;
    r.wd = DW'($urandom);
    return r;
  endfunction

  function automatic mreq_t rnd_req();
    mreq_t r;
    r = mk_req(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 2),
               $urandom_range(0, NC-1));
    r.hi = $urandom_range(0, 511);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) mq[i].delete();
    ev.delete(); er.delete(); din_hist.delete();
    for (int b = 0; b < NB; b++) orow[b] = -1;
    ptr = 0; free_c = 0; last_rsp = -1; plan_act = -1; cyc = 0; last_bank = 0;
  endtask

  task automatic put_ev(input int t, input bit [1:0] c, input mreq_t r);
    ev_t e;
    e.cmd = c; e.bank = r.bank; e.row = r.row; e.col = r.col;
    e.we = (c == 2'b10) && r.rw; e.wd = r.wd;
    ev[t] = e;
  endtask

  // Lay out the whole command timeline of one granted request.
  task automatic plan(input int id, input mreq_t r);
    int t, rc;
    rsp_t x;
    t = cyc + 1;
    plan_act = -1;
`ifdef OPEN_PAGE_EN
    if (orow[r.bank] != r.row) begin
      if (orow[r.bank] >= 0) begin put_ev(t, 2'b11, r); t += TRP; end
      put_ev(t, 2'b01, r); plan_act = t; t += TRCD;
    end
    orow[r.bank] = r.row;
`else
    put_ev(t, 2'b01, r); plan_act = t; t += TRCD;
`endif
    put_ev(t, 2'b10, r);
    rc = r.rw ? t + 1 : t + TCL + 1;
    x.id = id; x.rw = r.rw; x.dcyc = rc - 1;
    er[rc] = x;
`ifdef OPEN_PAGE_EN
    free_c = rc;
`else
    put_ev(rc, 2'b11, r); free_c = rc + TRP;
`endif
    last_rsp = rc;
  endtask

  task automatic step();
    logic [NREQ-1:0] rdy_e;
    logic [DW-1:0]   xd;
    int              win;
    ev_t             e;
    rsp_t            r;
    @(posedge clk); #1;
    req_valid = d_vld;
    for (int i = 0; i < NREQ; i++) begin
      req_rw[i]              = d_req[i].rw;
      req_addr[i*AW +: AW]   = mk_addr(d_req[i]);
      req_wdata[i*DW +: DW]  = d_req[i].wd;
    end
    dram_data_in   = DW'($urandom);
    din_hist[cyc]  = dram_data_in;
    @(negedge clk);
    e = '{default: 0};
    if (ev.exists(cyc)) e = ev[cyc];
    chk("cmd", 32'(cmd), 32'(e.cmd));
    chk("we", 32'(dram_we), 32'(e.we));
    if (e.cmd != 2'b00) begin
      chk("bank", 32'(bank_sel), e.bank);
      last_bank = e.bank;
    end else begin
      chk("bank_hold", 32'(bank_sel), last_bank);
    end
    if (e.cmd == 2'b01) chk("row", 32'(row_addr), e.row);
    if (e.cmd == 2'b10) chk("col", 32'(col_addr), e.col);
    if (e.we) chk("wdata", 32'(dram_data_out), 32'(e.wd));
    chk("rsp_valid", 32'(rsp_valid), 32'(er.exists(cyc)));
    if (er.exists(cyc)) begin
      r  = er[cyc];
      xd = r.rw ? '0 : din_hist[r.dcyc];
      chk("rsp_id", 32'(rsp_id), r.id);
      chk("rsp_rw", 32'(rsp_rw), 32'(r.rw));
      chk("rsp_data", 32'(rsp_data), 32'(xd));
    end
    for (int i = 0; i < NREQ; i++) rdy_e[i] = (mq[i].size() < QD);
    chk("ready", 32'(req_ready), 32'(rdy_e));
    if (cyc >= free_c) begin
      win = -1;
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (ptr + k) % NREQ;
        if (win < 0 && mq[j].size() > 0) win = j;
      end
      if (win >= 0) begin
        plan(win, mq[win].pop_front());
        ptr = (win + 1) % NREQ;
      end
    end
    for (int i = 0; i < NREQ; i++) if (d_vld[i] && rdy_e[i]) mq[i].push_back(d_req[i]);
    cyc++;
  endtask

  function automatic bit busy();
    bit b;
    b = (cyc <= last_rsp) || (cyc < free_c);
    for (int i = 0; i < NREQ; i++) if (mq[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain();
    int n;
    n = 0;
    d_vld = '0;
    while (busy() && n < 1000) begin step(); n++; end
    if (busy()) chk("drain_timeout", 32'(busy()), 0);
  endtask

  task automatic push1(input int ch, input mreq_t r);
    d_vld = '0;
    d_vld[ch] = 1'b1;
    d_req[ch] = r;
    step();
    d_vld = '0;
  endtask

  task automatic rnd_phase(input int n, input int pct);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        d_vld[i] = ($urandom_range(0, 99) < pct);
        d_req[i] = rnd_req();
      end
      step();
    end
    drain();
  endtask

  task automatic mid_reset();
    int n;
    n = 0;
    while ((plan_act < 0 || cyc <= plan_act) && n < 50) begin step(); n++; end
    if (n >= 50) chk("act_timeout", 32'(n), 0);
    @(posedge clk); #1;
    rst_b = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("mrst_cmd", 32'(cmd), 0);
    chk("mrst_rsp", 32'(rsp_valid), 0);
    chk("mrst_rdy", 32'(req_ready), 32'(ones));
    @(posedge clk); #1;
    rst_b = 1'b1;
    model_reset();
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    ones = '1;
    rst_b = 1'b0;
    d_vld = '0;
    for (int i = 0; i < NREQ; i++) d_req[i] = mk_req(1'b0, 0, 0, 0);
    req_valid = '0; req_rw = '0; req_addr = '0; req_wdata = '0; dram_data_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd", 32'(cmd), 0);
    chk("rst_rsp", 32'(rsp_valid), 0);
    chk("rst_rdy", 32'(req_ready), 32'(ones));
    chk("rst_bank", 32'(bank_sel), 0);
    chk("rst_we", 32'(dram_we), 0);
    chk("rst_id", 32'(rsp_id), 0);
    @(posedge clk); #1;
    rst_b = 1'b1;

    // cold read, row hit, row conflict on bank 2
    push1(0, mk_req(1'b0, 2, 5, 1)); drain();
    push1(0, mk_req(1'b0, 2, 5, 2)); drain();
    push1(0, mk_req(1'b0, 2, 6, 3)); drain();

    // round-robin ordering
    d_vld = '0;
    for (int i = 0; i < NREQ; i++) d_req[i] = rnd_req();
    d_vld[1] = 1'b1; d_vld[3] = 1'b1; d_vld[6] = 1'b1;
    step(); drain();
    for (int i = 0; i < NREQ; i++) d_req[i] = rnd_req();
    d_vld[1] = 1'b1; d_vld[6] = 1'b1;
    step(); drain();

    // fill channel 2 while a read is in flight
    push1(0, mk_req(1'b0, 4, 1, 0));
    for (int c = 0; c < 10; c++) begin
      d_vld = '0;
      d_vld[2] = 1'b1;
      d_req[2] = mk_req(1'b1, 3, c % 3, c % NC);
      step();
    end
    drain();

    // reset during the ACT-to-RW wait, then reuse the bank
    push1(0, mk_req(1'b0, 1, 3, 0)); drain();
    plan_act = -1;
    push1(0, mk_req(1'b0, 1, 4, 0));
    mid_reset();
    push1(0, mk_req(1'b0, 1, 4, 5)); drain();

    rnd_phase(600, 12);
    rnd_phase(300, 50);
    rnd_phase(200, 90);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/dram_sched_ctrl.md
Name: dram_sched_ctrl

Overview:
Parametrised successor to the fixed 8-port DRAM controller top. Accepts NUM_OF_REQ L2 request channels, each with its own valid/ready FIFO, and arbitrates among them round-robin. It splits each address into bank, row and column, tracks the open row per bank, and sequences PRE/ACT/RD-WR commands with programmable tRP/tRCD/tCL spacing. Sits between the L2 request ports and the DRAM bank array; one request in flight at a time.

Parameters:
NUM_OF_REQ, 8, number of L2 request channels (>=1)
ADDR_WIDTH, 22, request address width; bits above the bank/row/col fields are ignored
DATA_WIDTH, 1, data word width
NUM_OF_BANKS, 8, banks; BANK_W = $clog2(NUM_OF_BANKS)
NUM_OF_ROWS, 128, rows per bank; ROW_W = $clog2(NUM_OF_ROWS)
NUM_OF_COLS, 8, columns per row; COL_W = $clog2(NUM_OF_COLS)
QUEUE_DEPTH, 4, entries per channel FIFO (power of 2, >=2)
T_RP, 2, PRE-to-ACT spacing in cycles (>=1)
T_RCD, 2, ACT-to-RW spacing in cycles (>=1)
T_CL, 3, RD command to dram_data_in valid, in cycles (>=1)

Ports:
clk  in  1  clock
rst_b  in  1  asynchronous active-low reset
req_valid  in  NUM_OF_REQ  per-channel request valid
req_ready  out  NUM_OF_REQ  per-channel FIFO not full
req_rw  in  NUM_OF_REQ  1=write, 0=read
req_addr  in  NUM_OF_REQ*ADDR_WIDTH  channel i occupies [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_OF_REQ*DATA_WIDTH  write data, same packing
cmd  out  2  00 NOP, 01 ACT, 10 RD/WR, 11 PRE
bank_sel  out  BANK_W  target bank
row_addr  out  ROW_W  row, valid with ACT
col_addr  out  COL_W  column, valid with RD/WR
dram_we  out  1  high with cmd=10 for a write
dram_data_out  out  DATA_WIDTH  write data, valid with cmd=10 and dram_we=1
dram_data_in  in  DATA_WIDTH  read data, valid T_CL cycles after RD
rsp_valid  out  1  one-cycle completion pulse; no backpressure
rsp_id  out  $clog2(NUM_OF_REQ) (min 1)  channel that is completing
rsp_rw  out  1  rw of the completing request
rsp_data  out  DATA_WIDTH  read data; 0 for writes

Behaviour:
- Reset: all FIFOs are emptied, all banks are marked closed, the FSM goes to IDLE and the round-robin pointer is set to channel 0. All outputs are 0, except req_ready, which is all ones after reset.
- Address fields: col = addr[COL_W-1:0]; bank = addr[COL_W +: BANK_W]; row = addr[COL_W+BANK_W +: ROW_W].
- FIFO push: occurs when req_valid[i] && req_ready[i].
- req_ready[i]: equals !full[i] and is registered.
- Simultaneous push and pop on one FIFO is legal.
- A push into an empty FIFO becomes visible to the arbiter in the next cycle.
- IDLE: if any FIFO is non-empty, the head of the first non-empty channel at or after the pointer wins. The head is popped into the work register in that same cycle, and the pointer moves to winner+1, wrapping around.
- Next state after a grant:
  - bank open with matching row -> RW
  - bank open with a different row -> PRE
  - bank closed -> ACT
- PRE: cmd=11 for one cycle and the bank is marked closed. ACT is issued exactly T_RP cycles later.
- ACT: cmd=01 for one cycle and the row is recorded as open. RW is issued exactly T_RCD cycles later.
- RW: cmd=10 for one cycle in cycle n.
  - Write: dram_we=1, and rsp_valid is high in cycle n+1.
  - Read: dram_data_in is sampled at the end of cycle n+T_CL, and rsp_valid is high in cycle n+T_CL+1 with that data.
- Return to IDLE: the FSM enters IDLE in the rsp_valid cycle, so a new grant can occur in that cycle.
- cmd=00 in every cycle not listed above. bank_sel, row_addr and col_addr hold their values outside command cycles.
- No new grant is made while a request is in flight.

Optional Feature:
OPEN_PAGE_EN
- Defined: open-page policy. Rows stay open after access, so a same-row hit goes directly to RW.
- Undefined: closed-page policy. After each RW, and in the same cycle as rsp_valid, the FSM issues PRE to that bank. It then waits T_RP before returning to IDLE. Every access is therefore ACT->RW->PRE, and the hit path is never taken.

Test Plan:
- Reset: drive rst_b=0 mid-ACT_WAIT -> cmd=00, rsp_valid=0, req_ready=all ones on the next edge; after release, a new request to a previously opened bank starts with ACT.
- Cold read: ch0 read at addr 0x151 (bank2 row5 col1), OPEN_PAGE_EN defined -> ACT row 5 in grant+1, RD col 1 in grant+3, rsp_valid with rsp_id=0 in grant+7, rsp_data=dram_data_in at RD+3.
- Row hit versus conflict: after the cold read, read 0x152 -> RD in grant+1 with no ACT; then read bank2 row6 -> PRE, ACT 2 cycles later, RD 2 cycles after that.
- Round-robin: ch1, ch3 and ch6 all valid on the same cycle -> rsp_id order 1, 3, 6; then ch1 and ch6 again with pointer=7 -> order 1, 6.
- FIFO full: ch2 pushes 5 writes while blocked -> req_ready[2]=0 after 4 accepted; all 4 complete in order with rsp_rw=1 and rsp_data=0; the 5th is accepted only after the first pop.
- Closed page: OPEN_PAGE_EN undefined, two reads to the same row -> each shows ACT, RD, PRE; the second ACT occurs no earlier than 2 cycles after the first PRE.
